// File: rtl/cpu_trace_emitter.sv
// ---------------------------------------------------------------------------
// cpu_trace_emitter
//
// Takes one structured write record per valid/ready handshake and serialises
// it as an ASCII trace line, one character per clock, for cpu_checker:
//
//   register write : ^<time>@<pc>: $<grf> <= <data>#
//   memory write   : ^<time>@<pc>: *<addr> <= <data>#
//
// Parameters
//   UPPER_HEX  1 = hex digits a-f emitted as 'A'-'F', 0 = as 'a'-'f'
//   GAP        idle cycles inserted after '#' before accepting again (0..255)
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous reset, active low
//   in_valid    record offered
//   in_ready    emitter can accept a record (registered, high only in IDLE)
//   in_type     1 = register write, 2 = memory write, 0/3 = dropped
//   in_time     four BCD digits, most significant first
//   in_pc       instruction address
//   in_grf      register number (register writes only)
//   in_addr     memory address (memory writes only)
//   in_data     written value
//   char        current ASCII character, 8'h00 when char_valid is low
//   char_valid  char carries a record character this cycle
//   busy        a record is in flight
//   rec_count   number of completed records, wraps
// ---------------------------------------------------------------------------
module cpu_trace_emitter #(
  parameter int UPPER_HEX = 0,
  parameter int GAP       = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        busy,
  output logic [15:0] rec_count
);

  // ASCII codes used in the line
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_CARET = 8'h5E;  // '^'
  localparam logic [7:0] CH_AT    = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON = 8'h3A;  // ':'
  localparam logic [7:0] CH_SPACE = 8'h20;  // ' '
  localparam logic [7:0] CH_DOLR  = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR  = 8'h2A;  // '*'
  localparam logic [7:0] CH_LT    = 8'h3C;  // '<'
  localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
  localparam logic [7:0] CH_HASH  = 8'h23;  // '#'
  localparam logic [7:0] CH_ZERO  = 8'h30;  // '0'

  // Offset so that 10 + offset lands on 'a' or 'A'
  localparam logic [7:0] HEX_ALPHA_BASE = (UPPER_HEX != 0) ? 8'h37 : 8'h57;

  // WAIT counts down from GAP-1 to 0, giving exactly GAP cycles
  localparam logic [7:0] GAP_LAST = 8'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_COLSP,
    S_TAG,
    S_OPND,
    S_ARROW,
    S_DATA,
    S_HASH,
    S_WAIT
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;      // digit index inside a multi-char field
  logic [7:0]  gap_reg, gap_next;      // remaining WAIT cycles minus one

  logic [1:0]  type_reg;
  logic [15:0] time_reg;
  logic [31:0] pc_reg;
  logic [4:0]  grf_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;

  logic [7:0]  char_reg, char_next;
  logic        char_valid_reg, char_valid_next;
  logic        in_ready_reg;
  logic [15:0] rec_count_reg;

  logic        accept;

  logic [1:0]  tens_dec;
  logic [3:0]  ones_dec;

  logic [3:0]  time_nib;
  logic [3:0]  pc_nib;
  logic [3:0]  addr_nib;
  logic [3:0]  data_nib;

  assign in_ready   = in_ready_reg;
  assign char       = char_reg;
  assign char_valid = char_valid_reg;
  assign busy       = (state_reg != S_IDLE);
  assign rec_count  = rec_count_reg;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CH_ZERO + {4'h0, nib};
    end
    return HEX_ALPHA_BASE + {4'h0, nib};
  endfunction

  // Index of the most significant non-zero time digit; an all-zero time
  // still prints one digit, so the minimum is 0.
  function automatic logic [2:0] time_msd(input logic [15:0] t);
    if (t[15:12] != 4'h0) return 3'd3;
    if (t[11:8]  != 4'h0) return 3'd2;
    if (t[7:4]   != 4'h0) return 3'd1;
    return 3'd0;
  endfunction

  // Decimal split of the register number (0..31)
  always_comb begin
    tens_dec = 2'd0;
    ones_dec = 4'(grf_reg);
    if (grf_reg >= 5'd30) begin
      tens_dec = 2'd3;
      ones_dec = 4'(grf_reg - 5'd30);
    end else if (grf_reg >= 5'd20) begin
      tens_dec = 2'd2;
      ones_dec = 4'(grf_reg - 5'd20);
    end else if (grf_reg >= 5'd10) begin
      tens_dec = 2'd1;
      ones_dec = 4'(grf_reg - 5'd10);
    end
  end

  assign accept = in_valid && in_ready_reg;

  // Next-state and digit counter. Each state holds for as many cycles as it
  // has characters; cnt counts down so the last character is always cnt=0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    case (state_reg)
      S_IDLE: begin
        // Invalid types are consumed here without leaving IDLE
        if (accept && (in_type == 2'd1 || in_type == 2'd2)) begin
          state_next = S_CARET;
        end
      end
      S_CARET: begin
        state_next = S_TIME;
        cnt_next   = time_msd(time_reg);
      end
      S_TIME: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_AT;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_AT: begin
        state_next = S_PC;
        cnt_next   = 3'd7;
      end
      S_PC: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_COLSP;
          cnt_next   = 3'd1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_COLSP: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_TAG;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_TAG: begin
        state_next = S_OPND;
        if (type_reg == 2'd1) begin
          cnt_next = (grf_reg >= 5'd10) ? 3'd1 : 3'd0;
        end else begin
          cnt_next = 3'd7;
        end
      end
      S_OPND: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_ARROW;
          cnt_next   = 3'd3;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_ARROW: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_DATA;
          cnt_next   = 3'd7;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_DATA: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_HASH;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_HASH: begin
        if (GAP == 0) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT;
          gap_next   = GAP_LAST;
        end
      end
      S_WAIT: begin
        if (gap_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Character for the state/digit about to be entered, so char is registered
  // alongside the state that produced it.
  assign time_nib = time_reg[{cnt_next[1:0], 2'b00} +: 4];
  assign pc_nib   = pc_reg[{cnt_next, 2'b00} +: 4];
  assign addr_nib = addr_reg[{cnt_next, 2'b00} +: 4];
  assign data_nib = data_reg[{cnt_next, 2'b00} +: 4];

  always_comb begin
    char_next       = CH_NUL;
    char_valid_next = 1'b1;
    case (state_next)
      S_CARET: char_next = CH_CARET;
      // BCD digits above 9 deliberately fall through the hex table
      S_TIME:  char_next = hex_char(time_nib);
      S_AT:    char_next = CH_AT;
      S_PC:    char_next = hex_char(pc_nib);
      S_COLSP: char_next = cnt_next[0] ? CH_COLON : CH_SPACE;
      S_TAG:   char_next = (type_reg == 2'd1) ? CH_DOLR : CH_STAR;
      S_OPND: begin
        if (type_reg == 2'd1) begin
          char_next = cnt_next[0] ? (CH_ZERO + {6'h0, tens_dec})
                                  : (CH_ZERO + {4'h0, ones_dec});
        end else begin
          char_next = hex_char(addr_nib);
        end
      end
      S_ARROW: begin
        case (cnt_next[1:0])
          2'd2:    char_next = CH_LT;
          2'd1:    char_next = CH_EQ;
          default: char_next = CH_SPACE;
        endcase
      end
      S_DATA:  char_next = hex_char(data_nib);
      S_HASH:  char_next = CH_HASH;
      default: begin
        char_next       = CH_NUL;
        char_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 3'd0;
      gap_reg        <= 8'd0;
      type_reg       <= 2'd0;
      time_reg       <= 16'h0;
      pc_reg         <= 32'h0;
      grf_reg        <= 5'd0;
      addr_reg       <= 32'h0;
      data_reg       <= 32'h0;
      char_reg       <= CH_NUL;
      char_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      rec_count_reg  <= 16'h0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      gap_reg        <= gap_next;
      char_reg       <= char_next;
      char_valid_reg <= char_valid_next;
      // Ready is simply "will be in IDLE next cycle", so it rises one edge
      // after reset release and stays up across a dropped record.
      in_ready_reg   <= (state_next == S_IDLE);
      if (accept) begin
        type_reg <= in_type;
        time_reg <= in_time;
        pc_reg   <= in_pc;
        grf_reg  <= in_grf;
        addr_reg <= in_addr;
        data_reg <= in_data;
      end
      if (state_reg == S_HASH) begin
        rec_count_reg <= rec_count_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter. Three instances share the record fields:
//   0: lowercase hex, GAP=0   1: uppercase hex, GAP=0   2: lowercase, GAP=3
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  vld;
  logic [1:0]  in_type;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  logic        rdy  [3];
  logic [7:0]  ch_w [3];
  logic        cv   [3];
  logic        bsy  [3];
  logic [15:0] rc   [3];

  int n_vec = 0;
  int n_err = 0;
  int exp_rec [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      cpu_trace_emitter #(
        .UPPER_HEX((gi == 1) ? 1 : 0),
        .GAP      ((gi == 2) ? 3 : 0)
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (vld[gi]),
        .in_ready  (rdy[gi]),
        .in_type   (in_type),
        .in_time   (in_time),
        .in_pc     (in_pc),
        .in_grf    (in_grf),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .char      (ch_w[gi]),
        .char_valid(cv[gi]),
        .busy      (bsy[gi]),
        .rec_count (rc[gi])
      );
    end
  endgenerate

  function automatic string ns(input int v);
    return $sformatf("%0d", v);
  endfunction

  task automatic check(input string tag, input string got, input string exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [1:0] ty, input logic [15:0] tm,
                            input logic [31:0] pc, input logic [4:0] grf,
                            input logic [31:0] addr, input logic [31:0] data);
    in_type = ty;
    in_time = tm;
    in_pc   = pc;
    in_grf  = grf;
    in_addr = addr;
    in_data = data;
  endtask

  // Called at a negedge; returns at a negedge with in_ready high (or timeout)
  task automatic wait_ready(input int d);
    int w;
    w = 0;
    while (!rdy[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("dut%0d_ready_wait", d), ns(int'(rdy[d])), "1");
  endtask

  // Single-cycle offer; returns at the negedge after the accept edge
  task automatic send(input int d);
    wait_ready(d);
    vld[d] = 1'b1;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    @(negedge clk);
  endtask

  // Collects characters from the current negedge until '#'; ends on the
  // negedge that shows '#'. bub counts invalid cycles inside the line.
  task automatic capture(input int d, output string s, output int bub);
    int w;
    s   = "";
    bub = 0;
    w   = 0;
    while (!cv[d] && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 80; k++) begin
      if (cv[d]) begin
        s = {s, $sformatf("%c", ch_w[d])};
        if (ch_w[d] == 8'h23) break;
      end else begin
        bub++;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_rec(input int d, input logic [1:0] ty, input logic [15:0] tm,
                        input logic [31:0] pc, input logic [4:0] grf,
                        input logic [31:0] addr, input logic [31:0] data,
                        input string exp);
    string s;
    int    bub;
    set_fields(ty, tm, pc, grf, addr, data);
    send(d);
    capture(d, s, bub);
    $display("[dut%0d] %s", d, s);
    check($sformatf("dut%0d_line", d), s, exp);
    check($sformatf("dut%0d_bubbles", d), ns(bub), "0");
    @(negedge clk);
    exp_rec[d]++;
    check($sformatf("dut%0d_rec_count", d), ns(int'(rc[d])), ns(exp_rec[d]));
  endtask

  // Two records with in_valid held high; measures the idle gap between them
  task automatic btb(input int d, input int gap);
    string s;
    int    bub;
    int    idle;
    int    waitc;
    set_fields(2'd1, 16'h0242, 32'h0000_3130, 5'd31, 32'h0, 32'h1234_5678);
    wait_ready(d);
    vld[d] = 1'b1;
    @(negedge clk);
    capture(d, s, bub);
    $display("[dut%0d] %s", d, s);
    check($sformatf("dut%0d_btb_first", d), s, "^242@00003130: $31 <= 12345678#");
    set_fields(2'd2, 16'h0338, 32'h0000_3130, 5'd0, 32'h0000_0088, 32'hFFFF_B528);
    idle  = 0;
    waitc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cv[d]) break;
      idle++;
      if (!rdy[d]) waitc++;
    end
    vld[d] = 1'b0;
    capture(d, s, bub);
    $display("[dut%0d] %s", d, s);
    check($sformatf("dut%0d_btb_second", d), s, "^338@00003130: *00000088 <= ffffb528#");
    check($sformatf("dut%0d_btb_idle", d), ns(idle), ns(gap + 1));
    check($sformatf("dut%0d_btb_notready", d), ns(waitc), ns(gap));
    @(negedge clk);
    exp_rec[d] += 2;
    check($sformatf("dut%0d_btb_rec", d), ns(int'(rc[d])), ns(exp_rec[d]));
  endtask

  task automatic inv(input int d, input logic [1:0] ty);
    int ncv;
    int nlow;
    int nbusy;
    set_fields(ty, 16'h1234, 32'hFFFF_FFFF, 5'd5, 32'h1, 32'h2);
    wait_ready(d);
    vld[d] = 1'b1;
    @(posedge clk);
    #1 vld[d] = 1'b0;
    ncv   = 0;
    nlow  = 0;
    nbusy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ncv   += int'(cv[d]);
      nlow  += int'(!rdy[d]);
      nbusy += int'(bsy[d]);
    end
    $display("[dut%0d] invalid type %0d dropped", d, ty);
    check($sformatf("inv%0d_char_valid", ty), ns(ncv), "0");
    check($sformatf("inv%0d_ready_low", ty), ns(nlow), "0");
    check($sformatf("inv%0d_busy", ty), ns(nbusy), "0");
    check($sformatf("inv%0d_rec", ty), ns(int'(rc[d])), ns(exp_rec[d]));
  endtask

  initial begin
    vld     = 3'b000;
    reset_n = 1'b1;
    set_fields(2'd0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);

    // Asynchronous reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #2;
    check("rst_char", ns(int'(ch_w[0])), "0");
    check("rst_char_valid", ns(int'(cv[0])), "0");
    check("rst_in_ready", ns(int'(rdy[0])), "0");
    check("rst_busy", ns(int'(bsy[0])), "0");
    check("rst_rec_count", ns(int'(rc[0])), "0");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_before_edge", ns(int'(rdy[0])), "0");
    @(negedge clk);
    check("ready_after_edge", ns(int'(rdy[0])), "1");

    // Directed records
    do_rec(0, 2'd1, 16'h0242, 32'h0000_3130, 5'd31, 32'h0, 32'h1234_5678,
           "^242@00003130: $31 <= 12345678#");
    do_rec(0, 2'd2, 16'h0338, 32'h0000_3130, 5'd0, 32'h0000_0088, 32'hFFFF_B528,
           "^338@00003130: *00000088 <= ffffb528#");
    do_rec(1, 2'd2, 16'h0338, 32'h0000_3130, 5'd0, 32'h0000_0088, 32'hFFFF_B528,
           "^338@00003130: *00000088 <= FFFFB528#");
    do_rec(0, 2'd1, 16'h0000, 32'h0, 5'd0, 32'h0, 32'h0,
           "^0@00000000: $0 <= 00000000#");
    do_rec(0, 2'd1, 16'h0007, 32'h0, 5'd9, 32'h0, 32'h0,
           "^7@00000000: $9 <= 00000000#");
    do_rec(0, 2'd1, 16'h0A05, 32'hDEAD_BEEF, 5'd20, 32'h0, 32'hCAFE_0001,
           "^a05@deadbeef: $20 <= cafe0001#");
    do_rec(1, 2'd2, 16'h1000, 32'h0000_ABCD, 5'd0, 32'h8000_000F, 32'h0,
           "^1000@0000ABCD: *8000000F <= 00000000#");
    do_rec(0, 2'd1, 16'h0010, 32'h0000_0001, 5'd10, 32'h0, 32'h0000_0009,
           "^10@00000001: $10 <= 00000009#");
    do_rec(1, 2'd1, 16'h9999, 32'hFFFF_FFFF, 5'd19, 32'h0, 32'hA5A5_A5A5,
           "^9999@FFFFFFFF: $19 <= A5A5A5A5#");

    // Back-to-back streaming
    btb(0, 0);
    btb(2, 3);

    // Dropped records
    inv(0, 2'd0);
    inv(0, 2'd3);

    // Reset in the middle of the PC field
    set_fields(2'd1, 16'h0242, 32'h0000_3130, 5'd31, 32'h0, 32'h1234_5678);
    send(0);
    repeat (5) @(negedge clk);
    check("midrec_valid", ns(int'(cv[0])), "1");
    check("midrec_char", $sformatf("%c", ch_w[0]), "0");
    #2 reset_n = 1'b0;
    #1;
    check("midrst_char", ns(int'(ch_w[0])), "0");
    check("midrst_char_valid", ns(int'(cv[0])), "0");
    check("midrst_busy", ns(int'(bsy[0])), "0");
    check("midrst_rec_count", ns(int'(rc[0])), "0");
    exp_rec = '{0, 0, 0};
    @(negedge clk);
    reset_n = 1'b1;
    do_rec(0, 2'd1, 16'h0000, 32'h0, 5'd0, 32'h0, 32'h0,
           "^0@00000000: $0 <= 00000000#");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
